conv_8_32: RTL



---
 rtl/conv_8_32.sv | 84 ++++++++
 1 files changed

// File: rtl/conv_8_32.sv
// rtl/conv_8_32.sv - packs four accepted bytes into one 32-bit word, MSB first.
// Optional CONV_GAP_DISCARD_EN: a valid_in gap mid-word discards the partial word and pulses drop_out.
module conv_8_32 (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        drop_out
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [23:0] acc;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            idx       <= 2'd0;
            acc       <= 24'h000000;
            data_out  <= 32'h00000000;
            valid_out <= 1'b0;
            drop_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            drop_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        acc[23:16] <= data_in;
                        idx        <= 2'd1;
                        state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (valid_in) begin
                        case (idx)
                            2'd1: begin
                                acc[15:8] <= data_in;
                                idx       <= 2'd2;
                            end
                            2'd2: begin
                                acc[7:0] <= data_in;
                                idx      <= 2'd3;
                            end
                            2'd3: begin
                                // Word complete; returning to IDLE lets the next byte start a new word with no bubble.
                                data_out  <= {acc, data_in};
                                valid_out <= 1'b1;
                                idx       <= 2'd0;
                                state     <= IDLE;
                            end
                            default: begin
                                idx   <= 2'd0;
                                state <= IDLE;
                            end
                        endcase
                    end else begin
`ifdef CONV_GAP_DISCARD_EN
                        idx      <= 2'd0;
                        acc      <= 24'h000000;
                        state    <= IDLE;
                        drop_out <= 1'b1;
`else
                        // Gap tolerated: idx and acc hold until the next accepted byte.
                        idx      <= idx;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= 2'd0;
                end
            endcase
        end
    end

endmodule
